// File: rtl/div64by32_seq.sv
// Sequential restoring divider: a 2N-bit dividend divided by an N-bit divisor, one quotient bit
// per clock. Divide-by-zero and quotient overflow are resolved at start and finish early.
module div64by32_seq #(
    parameter int unsigned N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // The partial remainder is always below the divisor, so N bits hold it; only the shifted
    // trial value needs the extra bit.
    logic [N-1:0]  r_q, r_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  d_q, d_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [N:0]    trial;
    logic          fits;
    logic [N-1:0]  diff;
    logic [N-1:0]  r_next;
    logic [N-1:0]  q_shift;

    always_comb begin
        trial   = {r_q, q_q[N-1]};
        fits    = trial >= {1'b0, d_q};
        // Modular subtraction is exact whenever fits is set, since the result is below d_q.
        diff    = trial[N-1:0] - d_q;
        r_next  = fits ? diff : trial[N-1:0];
        q_shift = (q_q << 1) | N'(fits);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d = StDone;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        quot_d  = '1;
                        rem_d   = dividend[N-1:0];
                    end else if (dividend[2*N-1:N] >= divisor) begin
                        state_d = StDone;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = '0;
                    end else begin
                        state_d = StRun;
                        r_d     = dividend[2*N-1:N];
                        q_d     = dividend[N-1:0];
                        d_d     = divisor;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
            end
            StRun: begin
                r_d   = r_next;
                q_d   = q_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    quot_d  = q_shift;
                    rem_d   = r_next;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    // Working registers need no reset: they are always loaded before use.
    always_ff @(posedge clk) begin
        r_q <= r_d;
        q_q <= q_d;
        d_q <= d_d;
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_div64by32_seq.sv
// Self-checking bench for div64by32_seq: a transaction-level timing model checked every cycle,
// plus directed operations with hand-computed results.
module tb_div64by32_seq;

    localparam int unsigned N = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero, overflow;
    logic [31:0] quotient, remainder;

    always #5 clk = ~clk;

    div64by32_seq #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted normal operation finishes N+1 edges later with dividend/divisor results.
    logic        e_busy = 1'b0, e_done = 1'b0, e_dz = 1'b0, e_ov = 1'b0;
    logic [31:0] e_q = '0, e_r = '0, p_q = '0, p_r = '0;
    int          m_wait = 0;

    always @(posedge clk) begin
        if (rst) begin
            e_busy <= 1'b0; e_done <= 1'b0; e_dz <= 1'b0; e_ov <= 1'b0;
            e_q <= '0; e_r <= '0; m_wait <= 0;
        end else if (e_done) begin
            e_done <= 1'b0;
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                e_busy <= 1'b0; e_done <= 1'b1; e_q <= p_q; e_r <= p_r;
            end
        end else if (start) begin
            if (divisor == 0) begin
                e_done <= 1'b1; e_dz <= 1'b1; e_ov <= 1'b0;
                e_q <= '1; e_r <= dividend[31:0];
            end else if (dividend >= ({32'd0, divisor} << 32)) begin
                e_done <= 1'b1; e_dz <= 1'b0; e_ov <= 1'b1;
                e_q <= '1; e_r <= '0;
            end else begin
                e_busy <= 1'b1; e_dz <= 1'b0; e_ov <= 1'b0; m_wait <= N;
                p_q <= 32'(dividend / {32'd0, divisor});
                p_r <= 32'(dividend % {32'd0, divisor});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("busy", 64'(busy), 64'(e_busy));
        chk("done", 64'(done), 64'(e_done));
        chk("div_by_zero", 64'(div_by_zero), 64'(e_dz));
        chk("overflow", 64'(overflow), 64'(e_ov));
        if (!e_busy) begin
            chk("quotient", 64'(quotient), 64'(e_q));
            chk("remainder", 64'(remainder), 64'(e_r));
        end
    end

    // Starts an operation from an IDLE cycle; returns in the IDLE cycle after done.
    // p1/p2 are cycles during which start is raised again while the operation is running.
    task automatic do_op(input logic [63:0] a, input logic [31:0] b, input int p1, input int p2,
                         output logic [31:0] q, output logic [31:0] r, output logic dz,
                         output logic ov, output int lat, output int nbusy);
        dividend = a; divisor = b; start = 1'b1;
        lat = -1; nbusy = 0; q = '0; r = '0; dz = 1'b0; ov = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                start = 1'b0; dividend = {$urandom, $urandom}; divisor = $urandom;
            end
            if (busy) nbusy++;
            if (done) begin
                lat = c; q = quotient; r = remainder; dz = div_by_zero; ov = overflow;
                break;
            end
            start = (c == p1) || (c == p2);
        end
        start = 1'b0;
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL op_timeout: no done within 100 cycles for %0h / %0h", a, b);
        end
        @(posedge clk); #1;
    endtask

    logic [31:0] q, r, a, b, hi, lo;
    logic        dz, ov;
    int          lat, nb;

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset quotient", 64'(quotient), 64'd0);
        chk("reset remainder", 64'(remainder), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(64'd100, 32'd7, -1, -1, q, r, dz, ov, lat, nb);
        chk("100/7 q", 64'(q), 64'd14);
        chk("100/7 r", 64'(r), 64'd2);
        chk("100/7 flags", 64'({dz, ov}), 64'd0);
        chk("100/7 latency", 64'(lat), 64'd33);
        chk("100/7 busy cycles", 64'(nb), 64'd32);

        // Starts in the cycle right after the previous done.
        do_op(64'hFFFFFFFE_00000001, 32'hFFFFFFFF, -1, -1, q, r, dz, ov, lat, nb);
        chk("max q", 64'(q), 64'hFFFFFFFF);
        chk("max r", 64'(r), 64'd0);
        chk("max overflow", 64'(ov), 64'd0);
        chk("max latency", 64'(lat), 64'd33);

        do_op(64'h0000_0001_2345_6789, 32'd0, -1, -1, q, r, dz, ov, lat, nb);
        chk("dbz q", 64'(q), 64'hFFFFFFFF);
        chk("dbz r", 64'(r), 64'h23456789);
        chk("dbz flags", 64'({dz, ov}), 64'b10);
        chk("dbz latency", 64'(lat), 64'd1);
        chk("dbz busy cycles", 64'(nb), 64'd0);

        do_op(64'h00000005_00000000, 32'd5, -1, -1, q, r, dz, ov, lat, nb);
        chk("ovf q", 64'(q), 64'hFFFFFFFF);
        chk("ovf r", 64'(r), 64'd0);
        chk("ovf flags", 64'({dz, ov}), 64'b01);
        chk("ovf latency", 64'(lat), 64'd1);
        chk("ovf busy cycles", 64'(nb), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf held q", 64'(quotient), 64'hFFFFFFFF);

        do_op(64'd100, 32'd7, 5, 20, q, r, dz, ov, lat, nb);
        chk("poke q", 64'(q), 64'd14);
        chk("poke r", 64'(r), 64'd2);
        chk("poke latency", 64'(lat), 64'd33);
        chk("poke busy cycles", 64'(nb), 64'd32);

        // Reset in cycle 10 of a run.
        dividend = 64'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst quotient", 64'(quotient), 64'd0);
        chk("midrst remainder", 64'(remainder), 64'd0);
        chk("midrst flags", 64'({div_by_zero, overflow}), 64'd0);

        do_op(64'd1000, 32'd3, -1, -1, q, r, dz, ov, lat, nb);
        chk("after rst q", 64'(q), 64'd333);
        chk("after rst r", 64'(r), 64'd1);
        chk("after rst latency", 64'(lat), 64'd33);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if (b == 0) b = 32'd1;
            do_op({32'd0, a} * {32'd0, b}, b, -1, -1, q, r, dz, ov, lat, nb);
            chk("roundtrip q", 64'(q), 64'(a));
            chk("roundtrip r", 64'(r), 64'd0);
            chk("roundtrip flags", 64'({dz, ov}), 64'd0);
        end

        for (int i = 0; i < 200; i++) begin
            b = (i % 4 == 0) ? 32'($urandom_range(255, 1)) : $urandom;
            if (b == 0) b = 32'd1;
            hi = (i % 10 == 9) ? 32'hFFFFFFFF : ($urandom % b);
            lo = $urandom;
            do_op({hi, lo}, b, -1, -1, q, r, dz, ov, lat, nb);
            if (hi >= b) begin
                chk("rand ovf flag", 64'(ov), 64'd1);
                chk("rand ovf q", 64'(q), 64'hFFFFFFFF);
            end else begin
                chk("rand q", 64'(q), 64'({hi, lo} / {32'd0, b}));
                chk("rand r", 64'(r), 64'({hi, lo} % {32'd0, b}));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
